branch_fu: RTL and testbench

//  Branch functional unit, directly downstream of the branch reservation station.

---
 rtl/branch_fu_if.sv | 46 ++++
 rtl/branch_fu.sv | 153 +++++++++++++++
 tb/tb_branch_fu.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_fu_if.sv
// Issue-side and CDB-side signal bundle for the branch functional unit.
`timescale 1ns/1ps
interface branch_fu_if #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 5,
  parameter int PRF_IDX_W = 6
);
  logic                 squash;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_func;
  logic                 in_is_jal;
  logic                 in_is_jalr;
  logic [XLEN-1:0]      in_rs1;
  logic [XLEN-1:0]      in_rs2;
  logic [XLEN-1:0]      in_pc;
  logic [XLEN-1:0]      in_imm;
  logic                 in_pred_taken;
  logic [XLEN-1:0]      in_pred_target;
  logic [ROB_IDX_W-1:0] in_rob_idx;
  logic [PRF_IDX_W-1:0] in_prf_idx;
  logic                 out_valid;
  logic                 cdb_grant;
  logic [ROB_IDX_W-1:0] out_rob_idx;
  logic [PRF_IDX_W-1:0] out_prf_idx;
  logic [XLEN-1:0]      out_link;
  logic                 out_taken;
  logic [XLEN-1:0]      out_target;
  logic                 out_mispredict;

  modport master (
    output squash, in_valid, in_func, in_is_jal, in_is_jalr, in_rs1, in_rs2,
           in_pc, in_imm, in_pred_taken, in_pred_target, in_rob_idx, in_prf_idx,
           cdb_grant,
    input  in_ready, out_valid, out_rob_idx, out_prf_idx, out_link, out_taken,
           out_target, out_mispredict
  );

  modport slave (
    input  squash, in_valid, in_func, in_is_jal, in_is_jalr, in_rs1, in_rs2,
           in_pc, in_imm, in_pred_taken, in_pred_target, in_rob_idx, in_prf_idx,
           cdb_grant,
    output in_ready, out_valid, out_rob_idx, out_prf_idx, out_link, out_taken,
           out_target, out_mispredict
  );
endinterface

// File: rtl/branch_fu.sv
// Two-stage branch resolution unit: S1 latches the issued op and resolves it,
// S2 holds the result until the CDB grants it.
`timescale 1ns/1ps
module branch_fu #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 5,
  parameter int PRF_IDX_W = 6
) (
  input  logic     clock,
  input  logic     reset_n,
  branch_fu_if.slave bus
);

  typedef enum logic [2:0] {
    F_BEQ  = 3'b000,
    F_BNE  = 3'b001,
    F_BLT  = 3'b100,
    F_BGE  = 3'b101,
    F_BLTU = 3'b110,
    F_BGEU = 3'b111
  } func_e;

  logic                 s1_valid;
  logic [2:0]           s1_func;
  logic                 s1_is_jal;
  logic                 s1_is_jalr;
  logic [XLEN-1:0]      s1_rs1;
  logic [XLEN-1:0]      s1_rs2;
  logic [XLEN-1:0]      s1_pc;
  logic [XLEN-1:0]      s1_imm;
  logic                 s1_pred_taken;
  logic [XLEN-1:0]      s1_pred_target;
  logic [ROB_IDX_W-1:0] s1_rob_idx;
  logic [PRF_IDX_W-1:0] s1_prf_idx;

  logic                 s2_valid;
  logic [ROB_IDX_W-1:0] s2_rob_idx;
  logic [PRF_IDX_W-1:0] s2_prf_idx;
  logic [XLEN-1:0]      s2_link;
  logic                 s2_taken;
  logic [XLEN-1:0]      s2_target;
  logic                 s2_mispredict;

  logic                 s2_free;
  logic                 in_ready;
  logic                 s1_cond;
  logic                 s1_taken;
  logic [XLEN-1:0]      s1_target;
  logic [XLEN-1:0]      s1_link;
  logic [XLEN-1:0]      s1_next_pc;
  logic                 s1_mispredict;

  // S2 can take a new result when empty or when its current one leaves this edge;
  // a grant while S2 is empty is harmless because s2_free is already true.
  assign s2_free  = !s2_valid || bus.cdb_grant;
  assign in_ready = !bus.squash && (!s1_valid || s2_free);

  always_comb begin
    s1_cond = 1'b0;
    case (s1_func)
      F_BEQ:   s1_cond = (s1_rs1 == s1_rs2);
      F_BNE:   s1_cond = (s1_rs1 != s1_rs2);
      F_BLT:   s1_cond = ($signed(s1_rs1) <  $signed(s1_rs2));
      F_BGE:   s1_cond = ($signed(s1_rs1) >= $signed(s1_rs2));
      F_BLTU:  s1_cond = (s1_rs1 <  s1_rs2);
      F_BGEU:  s1_cond = (s1_rs1 >= s1_rs2);
      default: s1_cond = 1'b0;
    endcase
  end

  always_comb begin
    s1_link   = s1_pc + XLEN'(4);
    s1_target = s1_pc + s1_imm;
    s1_taken  = s1_cond;
    if (s1_is_jalr) begin
      s1_target = (s1_rs1 + s1_imm) & ~XLEN'(1);
      s1_taken  = 1'b1;
    end else if (s1_is_jal) begin
      s1_taken  = 1'b1;
    end
    s1_next_pc    = s1_taken ? s1_target : s1_link;
    s1_mispredict = (s1_taken != s1_pred_taken) ||
                    (s1_taken && (s1_target != s1_pred_target));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid       <= 1'b0;
      s1_func        <= '0;
      s1_is_jal      <= 1'b0;
      s1_is_jalr     <= 1'b0;
      s1_rs1         <= '0;
      s1_rs2         <= '0;
      s1_pc          <= '0;
      s1_imm         <= '0;
      s1_pred_taken  <= 1'b0;
      s1_pred_target <= '0;
      s1_rob_idx     <= '0;
      s1_prf_idx     <= '0;
    end else if (bus.squash) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_func        <= bus.in_func;
        s1_is_jal      <= bus.in_is_jal;
        s1_is_jalr     <= bus.in_is_jalr;
        s1_rs1         <= bus.in_rs1;
        s1_rs2         <= bus.in_rs2;
        s1_pc          <= bus.in_pc;
        s1_imm         <= bus.in_imm;
        s1_pred_taken  <= bus.in_pred_taken;
        s1_pred_target <= bus.in_pred_target;
        s1_rob_idx     <= bus.in_rob_idx;
        s1_prf_idx     <= bus.in_prf_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid      <= 1'b0;
      s2_rob_idx    <= '0;
      s2_prf_idx    <= '0;
      s2_link       <= '0;
      s2_taken      <= 1'b0;
      s2_target     <= '0;
      s2_mispredict <= 1'b0;
    end else if (bus.squash) begin
      s2_valid <= 1'b0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_rob_idx    <= s1_rob_idx;
        s2_prf_idx    <= s1_prf_idx;
        s2_link       <= s1_link;
        s2_taken      <= s1_taken;
        s2_target     <= s1_next_pc;
        s2_mispredict <= s1_mispredict;
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = s2_valid;
  assign bus.out_rob_idx    = s2_rob_idx;
  assign bus.out_prf_idx    = s2_prf_idx;
  assign bus.out_link       = s2_link;
  assign bus.out_taken      = s2_taken;
  assign bus.out_target     = s2_target;
  assign bus.out_mispredict = s2_mispredict;

endmodule

// File: tb/tb_branch_fu.sv
// Scoreboard bench for branch_fu: accepted ops push hand-computed results,
// a monitor pops and compares every result the CDB takes.
`timescale 1ns/1ps
module tb_branch_fu;

  typedef struct packed {
    logic [2:0]  func;
    logic        jal;
    logic        jalr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_taken;
    logic [31:0] e_target;
    logic        e_mis;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rob;
    logic [5:0]  prf;
    logic [31:0] link;
    logic        taken;
    logic [31:0] target;
    logic        mis;
  } exp_t;

  logic clock;
  logic reset_n;
  int   compared;
  int   mismatched;
  int   stall_cycles;
  logic [4:0] rob_tag;
  exp_t exp_in;
  exp_t sb[$];
  vec_t vecs[10];

  branch_fu_if #(.XLEN(32), .ROB_IDX_W(5), .PRF_IDX_W(6)) bus ();

  branch_fu #(.XLEN(32), .ROB_IDX_W(5), .PRF_IDX_W(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [2:0] func, input logic jal, input logic jalr,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic pt, input logic [31:0] ptgt,
                              input logic e_taken, input logic [31:0] e_target,
                              input logic e_mis);
    vec_t v;
    v.func = func; v.jal = jal; v.jalr = jalr; v.rs1 = rs1; v.rs2 = rs2;
    v.pc = pc; v.imm = imm; v.pt = pt; v.ptgt = ptgt;
    v.e_taken = e_taken; v.e_target = e_target; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Accepted ops enter the scoreboard at the edge that latches them.
  always @(negedge clock) begin
    if (reset_n && bus.in_valid && bus.in_ready) sb.push_back(exp_in);
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset_n && bus.out_valid && bus.cdb_grant) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_result: got rob=%0d target=%h, want no result",
                 bus.out_rob_idx, bus.out_target);
      end else begin
        e = sb.pop_front();
        if (bus.out_rob_idx !== e.rob || bus.out_prf_idx !== e.prf ||
            bus.out_link !== e.link || bus.out_taken !== e.taken ||
            bus.out_target !== e.target || bus.out_mispredict !== e.mis) begin
          mismatched++;
          $display("FAIL result: got rob=%0d prf=%0d link=%h taken=%0d target=%h mis=%0d, want rob=%0d prf=%0d link=%h taken=%0d target=%h mis=%0d",
                   bus.out_rob_idx, bus.out_prf_idx, bus.out_link, bus.out_taken,
                   bus.out_target, bus.out_mispredict,
                   e.rob, e.prf, e.link, e.taken, e.target, e.mis);
        end
      end
    end
  end

  task automatic drive_op(input vec_t v);
    bus.in_valid       = 1'b1;
    bus.in_func        = v.func;
    bus.in_is_jal      = v.jal;
    bus.in_is_jalr     = v.jalr;
    bus.in_rs1         = v.rs1;
    bus.in_rs2         = v.rs2;
    bus.in_pc          = v.pc;
    bus.in_imm         = v.imm;
    bus.in_pred_taken  = v.pt;
    bus.in_pred_target = v.ptgt;
    bus.in_rob_idx     = rob_tag;
    bus.in_prf_idx     = {1'b0, rob_tag} + 6'd3;
    exp_in.rob    = rob_tag;
    exp_in.prf    = {1'b0, rob_tag} + 6'd3;
    exp_in.link   = v.pc + 32'd4;
    exp_in.taken  = v.e_taken;
    exp_in.target = v.e_target;
    exp_in.mis    = v.e_mis;
    rob_tag = rob_tag + 5'd1;
  endtask

  task automatic wait_accept();
    int unsigned n;
    n = 0;
    @(negedge clock);
    while (!bus.in_ready && n < 20) begin
      n++;
      stall_cycles++;
      @(negedge clock);
    end
    if (!bus.in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, want acceptance", n);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input vec_t v);
    drive_op(v);
    wait_accept();
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_pending", 80'(sb.size()), 80'd0);
  endtask

  initial begin
    exp_t head;
    compared = 0; mismatched = 0; stall_cycles = 0; rob_tag = '0;
    exp_in = '0;
    vecs[0] = mk(3'b000, 0, 0, 32'd5,        32'd5, 32'h100,      32'h20,       0, 32'h0,    1, 32'h120,  1);
    vecs[1] = mk(3'b100, 0, 0, 32'hFFFFFFFF, 32'd1, 32'h200,      32'h40,       1, 32'h240,  1, 32'h240,  0);
    vecs[2] = mk(3'b110, 0, 0, 32'hFFFFFFFF, 32'd1, 32'h300,      32'h40,       1, 32'h340,  0, 32'h304,  1);
    vecs[3] = mk(3'b000, 0, 1, 32'h1001,     32'd0, 32'h400,      32'h2,        1, 32'h1002, 1, 32'h1002, 0);
    vecs[4] = mk(3'b001, 1, 0, 32'd0,        32'd0, 32'hFFFFFFF0, 32'h20,       0, 32'h0,    1, 32'h10,   1);
    vecs[5] = mk(3'b010, 0, 0, 32'd0,        32'd0, 32'h500,      32'h8,        0, 32'h0,    0, 32'h504,  0);
    vecs[6] = mk(3'b001, 0, 0, 32'd1,        32'd2, 32'h600,      32'hFFFFFFFC, 1, 32'h5FC,  1, 32'h5FC,  0);
    vecs[7] = mk(3'b101, 0, 0, 32'h80000000, 32'd0, 32'h700,      32'h10,       1, 32'h710,  0, 32'h704,  1);
    vecs[8] = mk(3'b111, 0, 0, 32'h80000000, 32'd0, 32'h800,      32'h10,       1, 32'h900,  1, 32'h810,  1);
    vecs[9] = mk(3'b011, 0, 0, 32'd7,        32'd7, 32'h900,      32'h4,        1, 32'h904,  0, 32'h904,  1);

    bus.squash = 1'b0; bus.cdb_grant = 1'b0; bus.in_valid = 1'b0;
    bus.in_func = '0; bus.in_is_jal = 1'b0; bus.in_is_jalr = 1'b0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_pc = '0; bus.in_imm = '0;
    bus.in_pred_taken = 1'b0; bus.in_pred_target = '0;
    bus.in_rob_idx = '0; bus.in_prf_idx = '0;

    reset_n = 1'b0;
    #2;
    chk("reset_ctrl", 80'({bus.out_valid, bus.out_taken, bus.out_mispredict,
                          bus.out_rob_idx, bus.out_prf_idx}), 80'd0);
    chk("reset_data", 80'({bus.out_link, bus.out_target}), 80'd0);
    #10 reset_n = 1'b1;
    @(negedge clock);
    chk("reset_in_ready", 80'(bus.in_ready), 80'd1);
    @(posedge clock); #1;

    // Single BEQ: result appears two edges after acceptance.
    bus.cdb_grant = 1'b1;
    issue(vecs[0]);
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("latency_s1", 80'(bus.out_valid), 80'd0);
    @(negedge clock);
    chk("latency_s2", 80'(bus.out_valid), 80'd1);
    @(posedge clock); #1;
    drain();

    // Back-to-back stream with grant held: no stalls.
    stall_cycles = 0;
    for (int i = 1; i < 10; i++) issue(vecs[i]);
    bus.in_valid = 1'b0;
    chk("throughput_stalls", 80'(stall_cycles), 80'd0);
    drain();

    // Backpressure: third op must wait while S2 holds the first result.
    bus.cdb_grant = 1'b0;
    issue(vecs[4]);
    issue(vecs[5]);
    drive_op(vecs[6]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      head = sb[0];
      chk("bp_in_ready", 80'(bus.in_ready), 80'd0);
      chk("bp_hold", 80'({bus.out_valid, bus.out_rob_idx, bus.out_target, bus.out_mispredict}),
          80'({1'b1, head.rob, head.target, head.mis}));
    end
    @(posedge clock); #1;
    bus.cdb_grant = 1'b1;
    wait_accept();
    bus.in_valid = 1'b0;
    drain();

    // Squash with both stages full; the op presented that cycle is dropped.
    bus.cdb_grant = 1'b0;
    issue(vecs[1]);
    issue(vecs[2]);
    drive_op(vecs[3]);
    bus.squash = 1'b1;
    @(negedge clock);
    chk("squash_in_ready", 80'(bus.in_ready), 80'd0);
    @(posedge clock); #1;
    bus.squash = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clock);
    chk("squash_out_valid", 80'(bus.out_valid), 80'd0);
    chk("squash_ready", 80'(bus.in_ready), 80'd1);
    @(posedge clock); #1;
    bus.cdb_grant = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    issue(vecs[8]);
    bus.in_valid = 1'b0;
    drain();

    // Asynchronous reset in the middle of a cycle with ops in flight.
    bus.cdb_grant = 1'b0;
    issue(vecs[6]);
    issue(vecs[7]);
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 80'({bus.out_valid, bus.out_taken, bus.out_mispredict,
                              bus.out_rob_idx, bus.out_prf_idx}), 80'd0);
    chk("async_rst_data", 80'({bus.out_link, bus.out_target}), 80'd0);
    sb.delete();
    #4 reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", 80'(bus.in_ready), 80'd1);
    chk("post_rst_valid", 80'(bus.out_valid), 80'd0);
    @(posedge clock); #1;
    bus.cdb_grant = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    issue(vecs[3]);
    bus.in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
